ibex_iter_multdiv_unit: RTL
===========================

Name: ibex_iter_multdiv_unit

Overview:
- Parametrised, width-generic iterative multiply/divide execution unit, successor to the fixed 32-bit multdiv path in the execution stage.
- Sits in EX beside the ALU but owns its own adder and operand and result registers, so it does not borrow the ALU.
- Uses valid/ready on both the input and output sides, supports a kill, and has configurable multiply radix and early-out.

Parameters:
- Width, 32: operand and result width; legal values 8, 16, 32, 64.
- MulBitsPerCycle, 1: multiplier bits retired per cycle; legal values 1, 2, 4; must divide Width.
- EarlyOut, 1: when 1, divide-by-zero and signed overflow complete in 1 cycle.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  unit can accept a request.
- op_i  in  2  operation: 00 MUL, 01 MULH, 10 DIV, 11 REM.
- signed_mode_i  in  2  bit0 = operand a signed, bit1 = operand b signed.
- op_a_i  in  Width  operand a; dividend for DIV/REM.
- op_b_i  in  Width  operand b; divisor for DIV/REM.
- data_ind_timing_i  in  1  when 1, forces EarlyOut behaviour off for the request being accepted.
- kill_i  in  1  abort any in-flight operation.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  Width  result.
- busy_o  out  1  an operation is in flight or a result is held.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state IDLE, out_valid_o=0, result_o=0, busy_o=0, in_ready_o=1. Reset asserted mid-operation discards all state immediately.
- States: IDLE, MUL, DIV, FIXUP, DONE.
- in_ready_o = (state==IDLE). Acceptance happens on in_valid_i & in_ready_o & ~kill_i in cycle T.
- On acceptance, op, signed mode, both operands and the early-out enable are latched. Inputs may change after T.
- busy_o = (state!=IDLE).
- MUL/MULH path:
  - MUL for N = Width/MulBitsPerCycle cycles (T+1..T+N), then DONE. out_valid_o rises at T+N+1.
  - MUL result = low Width bits of the exact 2*Width product.
  - MULH result = high Width bits, with each operand sign- or zero-extended per signed_mode_i. All four modes are legal (00 MULHU, 01 MULHSU, 11 MULH; 10 = a unsigned, b signed).
- DIV/REM path:
  - Signed only if signed_mode_i==11; every other value is unsigned.
  - Restoring division on magnitudes: DIV for Width cycles (T+1..T+Width), FIXUP for 1 cycle applying signs, then DONE. out_valid_o rises at T+Width+2.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Special cases (RISC-V semantics):
  - b==0: DIV returns all ones, REM returns a.
  - Signed a==most-negative and b==-1: DIV returns a, REM returns 0.
  - With EarlyOut=1 and data_ind_timing latched 0: T+1 goes straight to DONE, so out_valid_o rises at T+1.
  - Otherwise full latency with identical results.
- DONE:
  - result_o and out_valid_o are held stable until out_ready_i.
  - On the out handshake, go to IDLE next cycle. A new request is accepted no earlier than the cycle after the handshake; there is no bypass.
- result_o outside DONE: holds its last value and is not meaningful.
- kill_i:
  - In any state, next state is IDLE and out_valid_o=0 next cycle.
  - A kill in the same cycle as in_valid_i suppresses acceptance.
  - A kill in DONE together with out_ready_i still goes to IDLE. The consumer treats the result as taken.
- Arithmetic: internal accumulators are Width+1 bits for division and 2*Width+1 bits for multiplication. No overflow is reported.

Test Plan:
All scenarios use Width=32, MulBitsPerCycle=1, EarlyOut=1.
1. MUL 7×6 accepted at T -> out_valid_o at T+33, result 0x0000002A. Repeat with MulBitsPerCycle=4 -> T+9.
2. MULH mode 11, a=b=0x80000000 -> 0x40000000. MULHSU mode 01, a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF. MULHU mode 00, same operands -> 0x00000001.
3. DIV signed -7/2 -> 0xFFFFFFFD at T+34. REM signed -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF.
4. DIV 100/0 -> 0xFFFFFFFF at T+1. REM 100/0 -> 100. DIV signed 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1. Same requests with data_ind_timing_i=1 -> identical results at T+34.
5. DIV accepted, kill_i at T+10 -> out_valid_o never rises, in_ready_o=1 at T+11. A new MUL 3×3 then returns 9. Kill coincident with in_valid_i -> not accepted.
6. Result held with out_ready_i=0 for 5 cycles -> result_o and out_valid_o stable, in_ready_o=0. rst_i pulsed mid-DIV -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ibex_iter_multdiv_unit.sv
// Iterative multiply/divide unit for the EX stage. It has its own adder and its
// own operand, accumulator and result registers, so it never shares the ALU.
// Multiplication is shift-add, retiring MulBitsPerCycle multiplier bits per cycle.
// Division is restoring division on magnitudes, followed by a sign fixup cycle.
module ibex_iter_multdiv_unit #(
  parameter int Width           = 32,
  parameter int MulBitsPerCycle = 1,
  parameter bit EarlyOut        = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  input  logic             data_ind_timing_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o,
  output logic             busy_o
);

  localparam int K         = MulBitsPerCycle;
  localparam int MulCycles = Width / K;
  localparam int CntW      = $clog2(Width);
  localparam int PW        = Width + K + 2;   // upper partial sum before the shift
  localparam int AW        = 2 * Width + 1;   // {sign, high half, low half}

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_e;

  state_e state_q, state_d;

  // Control and result registers
  logic [CntW-1:0]  cnt_q;
  logic             op_sel_q;     // op bit 0: MULH vs MUL, REM vs DIV
  logic             b_sgn_q;      // multiplier is signed
  logic             dz_q;         // divide by zero
  logic             ovf_q;        // most-negative / -1
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [Width-1:0] result_q, result_d;

  // Datapath registers
  logic [Width-1:0]        a_q;
  logic signed [Width:0]   mul_a_q;
  logic [AW-1:0]           mul_acc_q, mul_acc_d;
  logic [Width-1:0]        rem_q, rem_d;
  logic [Width-1:0]        quo_q, quo_d;
  logic [Width-1:0]        den_q;

  // Two's-complement sign application used by both operand entry and fixup.
  function automatic logic [Width-1:0] apply_sign(input logic [Width-1:0] v,
                                                  input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // RISC-V results for divide-by-zero and signed overflow.
  function automatic logic [Width-1:0] special_result(input logic is_rem,
                                                      input logic dz,
                                                      input logic [Width-1:0] a);
    if (dz) return is_rem ? a : {Width{1'b1}};
    return is_rem ? {Width{1'b0}} : a;
  endfunction

  logic             accept;
  logic             div_sgn_in, a_neg_in, b_neg_in, dz_in, ovf_in, early_in;

  assign accept     = in_valid_i & (state_q == S_IDLE) & ~kill_i;
  assign div_sgn_in = (signed_mode_i == 2'b11);
  assign a_neg_in   = div_sgn_in & op_a_i[Width-1];
  assign b_neg_in   = div_sgn_in & op_b_i[Width-1];
  assign dz_in      = (op_b_i == {Width{1'b0}});
  assign ovf_in     = div_sgn_in & (op_a_i == {1'b1, {(Width-1){1'b0}}}) &
                      (op_b_i == {Width{1'b1}});
  assign early_in   = EarlyOut & ~data_ind_timing_i & op_i[1] & (dz_in | ovf_in);

  logic                           mul_last;
  logic signed [K:0]              mul_digit;
  logic signed [Width:0]          mul_hi;
  logic signed [PW-1:0]           mul_hi_sum;
  logic signed [PW+Width-1:0]     mul_wide;
  logic [Width:0]                 div_trial;

  // One shift-add multiply step and one restoring-division step.
  always_comb begin
    mul_last   = (cnt_q == '0);
    mul_digit  = {mul_last & b_sgn_q & mul_acc_q[K-1], mul_acc_q[K-1:0]};
    mul_hi     = mul_acc_q[AW-1:Width];
    mul_hi_sum = PW'(mul_hi) + PW'(mul_a_q) * PW'(mul_digit);
    mul_wide   = {mul_hi_sum, mul_acc_q[Width-1:0]};
    mul_acc_d  = AW'(mul_wide >>> K);

    div_trial  = {rem_q, quo_q[Width-1]} - {1'b0, den_q};
    if (!div_trial[Width]) begin
      rem_d = div_trial[Width-1:0];
      quo_d = {quo_q[Width-2:0], 1'b1};
    end else begin
      rem_d = {rem_q[Width-2:0], quo_q[Width-1]};
      quo_d = {quo_q[Width-2:0], 1'b0};
    end
  end

  // Next-state and result selection.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (early_in) begin
            state_d  = S_DONE;
            result_d = special_result(op_i[0], dz_in, op_a_i);
          end else begin
            state_d = op_i[1] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
        if (mul_last) begin
          state_d  = S_DONE;
          result_d = op_sel_q ? mul_acc_d[2*Width-1:Width] : mul_acc_d[Width-1:0];
        end
      end
      S_DIV: begin
        if (cnt_q == '0) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        state_d = S_DONE;
        if (dz_q || ovf_q) result_d = special_result(op_sel_q, dz_q, a_q);
        else if (op_sel_q) result_d = apply_sign(rem_q, neg_rem_q);
        else               result_d = apply_sign(quo_q, neg_quo_q);
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  // Control state, request attributes and the result register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_sel_q  <= 1'b0;
      b_sgn_q   <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        cnt_q     <= op_i[1] ? CntW'(Width - 1) : CntW'(MulCycles - 1);
        op_sel_q  <= op_i[0];
        b_sgn_q   <= signed_mode_i[1];
        dz_q      <= dz_in;
        ovf_q     <= ovf_in;
        neg_quo_q <= a_neg_in ^ b_neg_in;
        neg_rem_q <= a_neg_in;
      end else if ((state_q == S_MUL || state_q == S_DIV) && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Operand capture and accumulator iteration.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_q       <= op_a_i;
      mul_a_q   <= {signed_mode_i[0] & op_a_i[Width-1], op_a_i};
      mul_acc_q <= {{(Width+1){1'b0}}, op_b_i};
      rem_q     <= '0;
      quo_q     <= apply_sign(op_a_i, a_neg_in);
      den_q     <= apply_sign(op_b_i, b_neg_in);
    end else if (state_q == S_MUL) begin
      mul_acc_q <= mul_acc_d;
    end else if (state_q == S_DIV) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign result_o    = result_q;

endmodule
